multicycle_ctrl: RTL
====================

// Module: multicycle_ctrl
// PURPOSE
//  Moore/Mealy control FSM sequencing the multicycle MIPS datapath (PC, IR, MDR, A/B, ALUOut, regfile, unified mem).
//  Decodes op/funct from IR, drives every datapath mux select and write enable per state; waits on memory handshake.
//  Instantiated inside mips next to the datapath; only clk and reset are shared with the top level.
// PARAMETERS
//  MEM_WAIT_EN  1  1: FETCH/MEMRD/MEMWR hold until mem_ready; 0: mem_ready ignored (treated as 1)
// PORTS
//  clk           in   1  rising-edge clock, single domain
//  reset         in   1  synchronous, active-high
//  op            in   6  IR[31:26]
//  funct         in   6  IR[5:0]
//  zero          in   1  ALU zero flag (combinational, current cycle)
//  mem_ready     in   1  memory completes access this cycle
//  pc_write      out  1  PC load enable
//  iord          out  1  mem addr select: 0=PC, 1=ALUOut
//  mem_read      out  1  mem read strobe
//  mem_write     out  1  mem write strobe
//  ir_write      out  1  IR load enable
//  reg_write     out  1  regfile write enable
//  reg_dst       out  2  00=rt, 01=rd, 10=$31
//  mem_to_reg    out  2  00=ALUOut, 01=MDR, 10=PC (link)
//  ext_op        out  1  0=zero-extend imm16, 1=sign-extend
//  alu_src_a     out  1  0=PC, 1=A
//  alu_src_b     out  2  00=B, 01=const 4, 10=ext(imm), 11=ext(imm)<<2
//  alu_ctrl      out  3  ADD=000 SUB=001 AND=010 OR=011 SLT=100 SLL=101 LUI=110
//  pc_src        out  2  00=ALU result, 01=ALUOut, 10={PC[31:28],IR[25:0],2'b00}, 11=A (jr/jalr)
//  instr_done    out  1  one-cycle pulse in final state of each instruction
//  illegal       out  1  one-cycle pulse in DECODE on unsupported op/funct
//  state         out  4  current state (debug)
// BEHAVIOUR
//  Reset: state<=FETCH at edge with reset=1; while reset=1 all enables/strobes/pulses forced 0, selects 0.
//  States: FETCH=0 DECODE=1 MEMADR=2 MEMRD=3 MEMWB=4 MEMWR=5 EXE_R=6 ALUWB_R=7 EXE_I=8 ALUWB_I=9 BRANCH=10 JUMP=11.
//  FETCH: iord=0, mem_read=1, a=PC, b=4, ADD, pc_src=00; ir_write=pc_write=mem_ready; ->DECODE on mem_ready else stay.
//  DECODE: a=PC, b=11, ext_op=1, ADD (branch target into ALUOut). Next by op/funct:
//   lw/sw->MEMADR; R addu/subu/and/or/slt/sll->EXE_R; jr/jalr->JUMP; ori/addiu/lui->EXE_I; beq->BRANCH;
//   j/jal->JUMP; anything else -> illegal=1, ->FETCH, no writes.
//  MEMADR: a=A, b=10, ext_op=1, ADD; lw->MEMRD, sw->MEMWR.
//  MEMRD: iord=1, mem_read=1 held until mem_ready; ->MEMWB. MEMWB: reg_write=1, reg_dst=00, mem_to_reg=01; ->FETCH.
//  MEMWR: iord=1, mem_write=1 held until mem_ready; ->FETCH on mem_ready.
//  EXE_R: a=A, b=00, alu_ctrl from funct (sll=SLL, shamt taken by ALU from IR[10:6]); ->ALUWB_R.
//  ALUWB_R: reg_write=1, reg_dst=01, mem_to_reg=00; ->FETCH.
//  EXE_I: a=A, b=10; ori: OR, ext_op=0; addiu: ADD, ext_op=1; lui: LUI; ->ALUWB_I.
//  ALUWB_I: reg_write=1, reg_dst=00, mem_to_reg=00; ->FETCH.
//  BRANCH: a=A, b=00, SUB, pc_src=01, pc_write=zero (Mealy); ->FETCH.
//  JUMP: pc_write=1; j/jal pc_src=10, jr/jalr pc_src=11; jal: reg_write=1, reg_dst=10, mem_to_reg=10;
//   jalr: reg_write=1, reg_dst=01, mem_to_reg=10 (PC already PC+4); ->FETCH.
//  Latency (mem_ready=1): beq/j/jal/jr/jalr 3, R/I-ALU 4, sw 4, lw 5 cycles; each wait cycle adds 1.
//  instr_done=1 in MEMWB, MEMWR(mem_ready), ALUWB_R, ALUWB_I, BRANCH, JUMP.
//  Unused outputs in a state: enables 0, selects 0. No write enable ever asserted in DECODE/MEMADR/EXE_*.
//  Reset mid-instruction (any state, incl. mem wait): next edge FETCH, no pending write completes.
// STRUCTURE
//  Package mips_ctrl_pkg: state encodings, alu_ctrl codes, opcode/funct constants, mux-select constants.
//  One sub-module: mips_alu_dec (funct/op -> alu_ctrl, ext_op), combinational. State reg + next-state + output logic here.
// TESTING
//  addu $3,$1,$2 (op=0,funct=21h), mem_ready=1 -> states 0,1,6,7; reg_write=1 reg_dst=01 in cycle 4 only.
//  lw (op=23h), mem_ready low 2 cycles in MEMRD -> 7 cycles total; reg_write only in MEMWB, mem_to_reg=01.
//  beq (op=04h) zero=1 -> pc_write=1 pc_src=01 in cycle 3; zero=0 -> pc_write=0; instr_done=1 both.
//  jal (op=03h) -> JUMP: pc_src=10, reg_dst=10, mem_to_reg=10, reg_write=1; jr (funct=08h) -> pc_src=11, reg_write=0.
//  op=3Fh -> illegal pulse in DECODE, back to FETCH, zero writes; reset raised in MEMWR -> FETCH, mem_write=0.
//  MEM_WAIT_EN=0, mem_ready=0 held -> sw completes in 4 cycles, mem_write=1 exactly one cycle.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: states, ALU codes,
// opcode/funct values and datapath mux selects.
package mips_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned ALU_W   = 3;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXE_R   = 4'd6,
        S_ALUWB_R = 4'd7,
        S_EXE_I   = 4'd8,
        S_ALUWB_I = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b100;
    localparam logic [ALU_W-1:0] ALU_SLL = 3'b101;
    localparam logic [ALU_W-1:0] ALU_LUI = 3'b110;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'h00;
    localparam logic [OP_W-1:0] OP_J     = 6'h02;
    localparam logic [OP_W-1:0] OP_JAL   = 6'h03;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'h04;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'h09;
    localparam logic [OP_W-1:0] OP_ORI   = 6'h0D;
    localparam logic [OP_W-1:0] OP_LUI   = 6'h0F;
    localparam logic [OP_W-1:0] OP_LW    = 6'h23;
    localparam logic [OP_W-1:0] OP_SW    = 6'h2B;

    localparam logic [OP_W-1:0] FN_SLL  = 6'h00;
    localparam logic [OP_W-1:0] FN_JR   = 6'h08;
    localparam logic [OP_W-1:0] FN_JALR = 6'h09;
    localparam logic [OP_W-1:0] FN_ADDU = 6'h21;
    localparam logic [OP_W-1:0] FN_SUBU = 6'h23;
    localparam logic [OP_W-1:0] FN_AND  = 6'h24;
    localparam logic [OP_W-1:0] FN_OR   = 6'h25;
    localparam logic [OP_W-1:0] FN_SLT  = 6'h2A;

    localparam logic [SEL_W-1:0] SRCB_B     = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_BRIMM = 2'b11;

    localparam logic [SEL_W-1:0] REGDST_RT = 2'b00;
    localparam logic [SEL_W-1:0] REGDST_RD = 2'b01;
    localparam logic [SEL_W-1:0] REGDST_RA = 2'b10;

    localparam logic [SEL_W-1:0] M2R_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] M2R_MDR    = 2'b01;
    localparam logic [SEL_W-1:0] M2R_PC     = 2'b10;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JTGT   = 2'b10;
    localparam logic [SEL_W-1:0] PCSRC_REG    = 2'b11;

endpackage

// File: rtl/mips_alu_dec.sv
// ALU operation and immediate-extension decode from op/funct.
module mips_alu_dec
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl,
    output logic       ext_op
);

    // R-type ops select by funct, I-type ops by opcode
    always_comb begin
        alu_ctrl = ALU_ADD;
        ext_op   = 1'b0;
        if (op == OP_RTYPE) begin
            case (funct)
                FN_SUBU: alu_ctrl = ALU_SUB;
                FN_AND:  alu_ctrl = ALU_AND;
                FN_OR:   alu_ctrl = ALU_OR;
                FN_SLT:  alu_ctrl = ALU_SLT;
                FN_SLL:  alu_ctrl = ALU_SLL;
                default: alu_ctrl = ALU_ADD;
            endcase
        end else begin
            case (op)
                OP_ORI:   alu_ctrl = ALU_OR;
                OP_LUI:   alu_ctrl = ALU_LUI;
                OP_ADDIU: begin
                    alu_ctrl = ALU_ADD;
                    ext_op   = 1'b1;
                end
                default:  alu_ctrl = ALU_ADD;
            endcase
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle MIPS datapath. Outputs follow the current
// state plus the same-cycle mem_ready/zero inputs, so they are combinational.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned MEM_WAIT_EN = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       ext_op,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_ctrl,
    output logic [1:0] pc_src,
    output logic       instr_done,
    output logic       illegal,
    output logic [3:0] state
);

    state_t     st;
    state_t     nxt;
    logic       ready;
    logic [2:0] dec_alu;
    logic       dec_ext;
    logic       is_rtype;

    mips_alu_dec u_alu_dec (
        .op       (op),
        .funct    (funct),
        .alu_ctrl (dec_alu),
        .ext_op   (dec_ext)
    );

    assign ready    = (MEM_WAIT_EN == 0) ? 1'b1 : mem_ready;
    assign is_rtype = (op == OP_RTYPE);
    assign state    = STATE_W'(st);

    // State register
    always_ff @(posedge clk) begin
        if (reset) st <= S_FETCH;
        else       st <= nxt;
    end

    // Next state and per-state datapath controls; all forced idle during reset
    always_comb begin
        nxt        = st;
        pc_write   = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = REGDST_RT;
        mem_to_reg = M2R_ALUOUT;
        ext_op     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        alu_ctrl   = ALU_ADD;
        pc_src     = PCSRC_ALU;
        instr_done = 1'b0;
        illegal    = 1'b0;
        case (st)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = ready;
                pc_write  = ready;
                if (ready) nxt = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b = SRCB_BRIMM;
                ext_op    = 1'b1;
                case (op)
                    OP_LW, OP_SW:             nxt = S_MEMADR;
                    OP_ORI, OP_ADDIU, OP_LUI: nxt = S_EXE_I;
                    OP_BEQ:                   nxt = S_BRANCH;
                    OP_J, OP_JAL:             nxt = S_JUMP;
                    OP_RTYPE: begin
                        case (funct)
                            FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_SLL:
                                nxt = S_EXE_R;
                            FN_JR, FN_JALR:
                                nxt = S_JUMP;
                            default: begin
                                illegal = 1'b1;
                                nxt     = S_FETCH;
                            end
                        endcase
                    end
                    default: begin
                        illegal = 1'b1;
                        nxt     = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                ext_op    = 1'b1;
                nxt       = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (ready) nxt = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
                instr_done = 1'b1;
                nxt        = S_FETCH;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                mem_write  = 1'b1;
                instr_done = ready;
                if (ready) nxt = S_FETCH;
            end
            S_EXE_R: begin
                alu_src_a = 1'b1;
                alu_ctrl  = dec_alu;
                nxt       = S_ALUWB_R;
            end
            S_ALUWB_R: begin
                reg_write  = 1'b1;
                reg_dst    = REGDST_RD;
                instr_done = 1'b1;
                nxt        = S_FETCH;
            end
            S_EXE_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_ctrl  = dec_alu;
                ext_op    = dec_ext;
                nxt       = S_ALUWB_I;
            end
            S_ALUWB_I: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                nxt        = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_ctrl   = ALU_SUB;
                pc_src     = PCSRC_ALUOUT;
                pc_write   = zero;
                instr_done = 1'b1;
                nxt        = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                instr_done = 1'b1;
                nxt        = S_FETCH;
                if (is_rtype) begin
                    pc_src = PCSRC_REG;
                    if (funct == FN_JALR) begin
                        reg_write  = 1'b1;
                        reg_dst    = REGDST_RD;
                        mem_to_reg = M2R_PC;
                    end
                end else begin
                    pc_src = PCSRC_JTGT;
                    if (op == OP_JAL) begin
                        reg_write  = 1'b1;
                        reg_dst    = REGDST_RA;
                        mem_to_reg = M2R_PC;
                    end
                end
            end
            default: nxt = S_FETCH;
        endcase
        if (reset) begin
            pc_write   = 1'b0;
            iord       = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            reg_write  = 1'b0;
            reg_dst    = REGDST_RT;
            mem_to_reg = M2R_ALUOUT;
            ext_op     = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = SRCB_B;
            alu_ctrl   = ALU_ADD;
            pc_src     = PCSRC_ALU;
            instr_done = 1'b0;
            illegal    = 1'b0;
        end
    end

endmodule
